multi_timer: RTL and testbench
==============================

Name: multi_timer

Overview:
- Parametrised bank of C_NUM_TIMERS independent up-counters, each with limit, prescaler, one-shot/periodic mode and sticky DONE flag.
- Configured and read over a single AXI4-Lite slave from the PS.
- Exports each channel's count and running flag to fabric consumers such as timestamping and traffic generators.

Parameters:
C_NUM_TIMERS, 4, number of channels, 1..8
C_WIDTH, 64, counter width in bits, 33..64
C_AXI_ADDR_WIDTH, 12, AXI address width; must satisfy C_NUM_TIMERS*32 <= 2**C_AXI_ADDR_WIDTH

Ports:
clk  in  1  single clock for all logic
rst_n  in  1  asynchronous active-low reset
current_time  out  C_NUM_TIMERS*C_WIDTH  channel n count at [n*C_WIDTH +: C_WIDTH]
time_running  out  C_NUM_TIMERS  channel n BUSY
irq  out  1  OR of (DONE & IRQ_EN) over all channels; present only with TIMER_IRQ_EN, otherwise tied 0
s_axi_*  mixed  std  AXI4-Lite slave: awaddr/araddr C_AXI_ADDR_WIDTH, wdata/rdata 32, wstrb 4, prot 3, resp 2

Behaviour:
- Reset: all registers, counts, prescalers and DONE bits are 0. All outputs are 0: irq, time_running, every AXI valid/ready.
- Channel n register block base is 0x20*n:
  - +0x00 CFG: RW. Bit 0 EN, bit 1 SRST, bit 2 PERIODIC, bit 3 IRQ_EN.
  - +0x04 STATUS: bit 0 BUSY (RO), bit 1 DONE (W1C).
  - +0x08 PRESCALE: RW, 32 bits.
  - +0x10 LIMIT_L, +0x14 LIMIT_H: RW; unimplemented upper bits of LIMIT_H read 0.
  - +0x18 COUNT_L, +0x1C COUNT_H: RO.
  - +0x0C and unmapped addresses: read 0, writes ignored. All responses OKAY.
- Write path:
  - awready and wready pulse together for one cycle, only when awvalid & wvalid & ~bvalid.
  - bvalid rises the next cycle and holds until bready.
  - wstrb is honoured bytewise.
  - The register updates on the cycle after the handshake.
- Read path:
  - arready is high when rvalid is low.
  - rdata is registered; rvalid rises the cycle after the AR handshake and holds until rready.
- 64-bit read coherence:
  - A COUNT_L read captures the channel's upper count bits into a shadow register.
  - COUNT_H returns the shadow. COUNT_H without a prior COUNT_L returns the last shadow (0 after reset).
- Prescaler and tick:
  - Prescale counter p runs while BUSY.
  - tick = (p == PRESCALE). On tick p <= 0, else p <= p+1.
  - PRESCALE=0 gives a tick every cycle.
- BUSY (combinational) = EN & ~SRST & (LIMIT != 0) & (PERIODIC | count < LIMIT).
- One-shot mode: on tick while BUSY, count <= count+1. When count+1 == LIMIT, DONE is set and BUSY falls the following cycle.
- Periodic mode: on tick while BUSY:
  - if count >= LIMIT-1, then count <= 0 and DONE set;
  - else count <= count+1.
  - Period is LIMIT*(PRESCALE+1) cycles.
- SRST=1 holds count, p and DONE at 0. CFG, LIMIT and PRESCALE keep their values. SRST stays set until software writes 0.
- EN=0 freezes count and p; re-enabling resumes counting.
- LIMIT written below the current count while running:
  - one-shot stops immediately, with no DONE;
  - periodic wraps to 0 on the next tick and sets DONE.
- A DONE W1C in the same cycle as a DONE set: the set wins.
- Count never exceeds LIMIT, so no wrap-around is possible in one-shot mode.
- rst_n asserted mid-transaction drops bvalid/rvalid immediately and discards the pending write.

Optional Feature:
- Macro TIMER_IRQ_EN.
- When defined: the irq port exists, and the CFG IRQ_EN bit is writable. irq is registered (one cycle after DONE sets) and stays high until every enabled DONE is cleared.
- When undefined: irq is driven 0, IRQ_EN reads 0 and writes to it are ignored.

Test Plan:
- Ch0: LIMIT=10, PRESCALE=0, CFG=0x1 -> BUSY for 10 cycles, COUNT=10, DONE=1, time_running[0] falls; count stays 10.
- Ch1: LIMIT=4, PRESCALE=2, CFG=0x5 -> count sequence 0,1,2,3,0 with each value held 3 cycles; DONE set every 12 cycles. W1C to DONE in the set cycle -> DONE stays 1.
- Ch2: LIMIT=0x1_0000_0005, preset near 0xFFFF_FFFF by running -> COUNT_L read then COUNT_H read gives a coherent 64-bit value across the 32-bit carry.
- Ch0 running with count=6: write CFG=0x3 -> count=0, DONE=0, BUSY=0; then CFG=0x1 -> restarts from 0, LIMIT unchanged.
- TIMER_IRQ_EN defined: ch3 IRQ_EN=1, one-shot LIMIT=3 -> irq high 1 cycle after DONE; clear DONE -> irq low. Undefined -> irq stays 0.
- AXI: awvalid asserted 3 cycles before wvalid -> single write and single bvalid; bready held low 5 cycles -> bvalid held, no new handshake accepted.

Source files
------------

// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - AXI4-Lite configured bank of prescaled up-counters
// Optional: define TIMER_IRQ_EN to enable the CFG IRQ_EN bit and a registered irq output.
module multi_timer #(
    parameter int C_NUM_TIMERS     = 4,
    parameter int C_WIDTH          = 64,
    parameter int C_AXI_ADDR_WIDTH = 12
) (
    input  logic                              clk,
    input  logic                              rst_n,
    output logic [C_NUM_TIMERS*C_WIDTH-1:0]   current_time,
    output logic [C_NUM_TIMERS-1:0]           time_running,
    output logic                              irq,
    input  logic [C_AXI_ADDR_WIDTH-1:0]       s_axi_awaddr,
    input  logic [2:0]                        s_axi_awprot,
    input  logic                              s_axi_awvalid,
    output logic                              s_axi_awready,
    input  logic [31:0]                       s_axi_wdata,
    input  logic [3:0]                        s_axi_wstrb,
    input  logic                              s_axi_wvalid,
    output logic                              s_axi_wready,
    output logic [1:0]                        s_axi_bresp,
    output logic                              s_axi_bvalid,
    input  logic                              s_axi_bready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]       s_axi_araddr,
    input  logic [2:0]                        s_axi_arprot,
    input  logic                              s_axi_arvalid,
    output logic                              s_axi_arready,
    output logic [31:0]                       s_axi_rdata,
    output logic [1:0]                        s_axi_rresp,
    output logic                              s_axi_rvalid,
    input  logic                              s_axi_rready
);
    localparam int CHW = C_AXI_ADDR_WIDTH - 5;
    localparam int HW  = C_WIDTH - 32;
    localparam logic [C_WIDTH-1:0] ONE = C_WIDTH'(1);
`ifdef TIMER_IRQ_EN
    localparam logic [3:0] CFG_MASK = 4'hF;
`else
    localparam logic [3:0] CFG_MASK = 4'h7;
`endif

    logic                        ready_en;
    logic                        aw_hs, ar_hs;
    logic                        wr_pend;
    logic [C_AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]                 wr_data;
    logic [3:0]                  wr_strb;
    logic [CHW-1:0]              wr_ch, rd_ch;
    logic [2:0]                  wr_reg, rd_reg;
    logic [31:0]                 rd_val;

    logic [3:0]         cfg_a [C_NUM_TIMERS];
    logic [31:0]        pre_a [C_NUM_TIMERS];
    logic [C_WIDTH-1:0] lim_a [C_NUM_TIMERS];
    logic [C_WIDTH-1:0] cnt_a [C_NUM_TIMERS];
    logic [HW-1:0]      shd_a [C_NUM_TIMERS];
    logic [C_NUM_TIMERS-1:0] busy, done, irq_en;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[b*8 +: 8] = data[b*8 +: 8];
        return r;
    endfunction

    // ready_en keeps every ready low until the first clock after reset release
    assign aw_hs         = s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid & ready_en;
    assign s_axi_awready = aw_hs;
    assign s_axi_wready  = aw_hs;
    assign s_axi_arready = ready_en & ~s_axi_rvalid;
    assign ar_hs         = s_axi_arvalid & s_axi_arready;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_rresp   = 2'b00;

    assign wr_ch  = wr_addr[C_AXI_ADDR_WIDTH-1:5];
    assign wr_reg = wr_addr[4:2];
    assign rd_ch  = s_axi_araddr[C_AXI_ADDR_WIDTH-1:5];
    assign rd_reg = s_axi_araddr[4:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en     <= 1'b0;
            wr_pend      <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            wr_strb      <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
        end else begin
            ready_en <= 1'b1;
            wr_pend  <= aw_hs;
            if (aw_hs) begin
                wr_addr <= s_axi_awaddr;
                wr_data <= s_axi_wdata;
                wr_strb <= s_axi_wstrb;
            end
            if (aw_hs)
                s_axi_bvalid <= 1'b1;
            else if (s_axi_bready)
                s_axi_bvalid <= 1'b0;
            if (ar_hs) begin
                s_axi_rdata  <= rd_val;
                s_axi_rvalid <= 1'b1;
            end else if (s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < C_NUM_TIMERS; gi++) begin : g_ch
            logic [3:0]         cfg;
            logic [31:0]        pre, p;
            logic [C_WIDTH-1:0] lim, cnt, cnt_inc;
            logic [HW-1:0]      shd;
            logic               done_q, sel, tick, wrap, per;
            logic [31:0]        cfg_w, pre_w, liml_w, limh_w;

            assign sel      = wr_pend && (wr_ch == CHW'(gi));
            assign per      = cfg[2];
            assign cnt_inc  = cnt + ONE;
            assign busy[gi] = cfg[0] & ~cfg[1] & (lim != '0) & (per | (cnt < lim));
            assign tick     = busy[gi] & (p == pre);
            assign wrap     = per ? (cnt >= lim - ONE) : (cnt_inc == lim);
            assign cfg_w    = merge({28'b0, cfg}, wr_data, wr_strb);
            assign pre_w    = merge(pre, wr_data, wr_strb);
            assign liml_w   = merge(lim[31:0], wr_data, wr_strb);
            assign limh_w   = merge(32'(lim[C_WIDTH-1:32]), wr_data, wr_strb);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cfg    <= '0;
                    pre    <= '0;
                    lim    <= '0;
                    cnt    <= '0;
                    p      <= '0;
                    shd    <= '0;
                    done_q <= 1'b0;
                end else begin
                    if (sel) begin
                        case (wr_reg)
                            3'd0:    cfg <= cfg_w[3:0] & CFG_MASK;
                            3'd2:    pre <= pre_w;
                            3'd4:    lim[31:0] <= liml_w;
                            3'd5:    lim[C_WIDTH-1:32] <= limh_w[HW-1:0];
                            default: ;
                        endcase
                    end
                    // SRST pins the run state at zero but leaves the configuration alone
                    if (cfg[1]) begin
                        cnt    <= '0;
                        p      <= '0;
                        done_q <= 1'b0;
                    end else begin
                        if (busy[gi]) p <= tick ? '0 : p + 32'd1;
                        if (tick) cnt <= (per && wrap) ? '0 : cnt_inc;
                        if (tick && wrap)
                            done_q <= 1'b1;
                        else if (sel && wr_reg == 3'd1 && wr_strb[0] && wr_data[1])
                            done_q <= 1'b0;
                    end
                    if (ar_hs && rd_ch == CHW'(gi) && rd_reg == 3'd6)
                        shd <= cnt[C_WIDTH-1:32];
                end
            end

            assign cfg_a[gi]  = cfg;
            assign pre_a[gi]  = pre;
            assign lim_a[gi]  = lim;
            assign cnt_a[gi]  = cnt;
            assign shd_a[gi]  = shd;
            assign done[gi]   = done_q;
            assign irq_en[gi] = cfg[3];
            assign current_time[gi*C_WIDTH +: C_WIDTH] = cnt;
        end
    endgenerate

    assign time_running = busy;

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < C_NUM_TIMERS; i++) begin
            if (rd_ch == CHW'(i)) begin
                case (rd_reg)
                    3'd0:    rd_val = {28'b0, cfg_a[i]};
                    3'd1:    rd_val = {30'b0, done[i], busy[i]};
                    3'd2:    rd_val = pre_a[i];
                    3'd4:    rd_val = lim_a[i][31:0];
                    3'd5:    rd_val = 32'(lim_a[i][C_WIDTH-1:32]);
                    3'd6:    rd_val = cnt_a[i][31:0];
                    3'd7:    rd_val = 32'(shd_a[i]);
                    default: rd_val = '0;
                endcase
            end
        end
    end

`ifdef TIMER_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq <= 1'b0;
        else        irq <= |(done & irq_en);
    end
    logic unused_ok;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, wr_addr[1:0], s_axi_araddr[1:0]};
`else
    assign irq = 1'b0;
    logic unused_ok;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, wr_addr[1:0], s_axi_araddr[1:0], irq_en};
`endif
endmodule

// File: tb/tb_multi_timer.sv
// tb/tb_multi_timer.sv - randomized and directed self-checking bench for multi_timer
module tb_multi_timer;
    localparam int N = 4;
    localparam int W = 64;
`ifdef TIMER_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
    localparam logic [31:0] CFG3_EXP = 32'h9;
`else
    localparam logic IRQ_ON = 1'b0;
    localparam logic [31:0] CFG3_EXP = 32'h1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic [N*W-1:0] current_time;
    logic [N-1:0] time_running;
    logic irq;
    logic [11:0] awaddr, araddr;
    logic [2:0] awprot, arprot;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0] wstrb;
    logic [1:0] bresp, rresp;

    int checks = 0;
    int errors = 0;
    longint unsigned cyc = 0;

    longint unsigned m_start [N];
    longint unsigned m_pre [N];
    logic [63:0] m_lim [N];
    bit m_per [N];
    bit m_active [N];
    bit m_mon [N];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multi_timer dut (
        .clk(clk), .rst_n(rst_n), .current_time(current_time), .time_running(time_running), .irq(irq),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] regaddr(input int ch, input int off);
        return 12'(ch * 32 + off);
    endfunction

    // Reference: a started channel has seen floor(elapsed/(PRESCALE+1)) ticks.
    function automatic longint unsigned m_ticks(input int ch, input longint unsigned n);
        return (n - m_start[ch]) / (m_pre[ch] + 1);
    endfunction

    function automatic logic [63:0] m_count(input int ch, input longint unsigned n);
        longint unsigned k;
        if (!m_active[ch]) return 64'd0;
        k = m_ticks(ch, n);
        if (m_per[ch]) return k % m_lim[ch];
        return (k < m_lim[ch]) ? k : m_lim[ch];
    endfunction

    function automatic bit m_busy(input int ch, input longint unsigned n);
        if (!m_active[ch]) return 1'b0;
        return m_per[ch] || (m_ticks(ch, n) < m_lim[ch]);
    endfunction

    function automatic bit m_done(input int ch, input longint unsigned n);
        if (!m_active[ch]) return 1'b0;
        return m_ticks(ch, n) >= m_lim[ch];
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int c = 0; c < N; c++) begin
                if (m_mon[c]) begin
                    check($sformatf("time%0d", c), current_time[c*W +: W], m_count(c, cyc));
                    check($sformatf("run%0d", c), 64'(time_running[c]), 64'(m_busy(c, cyc)));
                end
            end
        end
    end

    // All tasks are entered and left just after a falling edge.
    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             output longint unsigned applied);
        int t = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        while (!(awready && wready) && t < 20) begin
            @(negedge clk); #1; t++;
        end
        check("wr_ready", 64'(awready & wready), 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check("bvalid", 64'(bvalid), 64'd1);
        check("bresp", 64'(bresp), 64'd0);
        @(posedge clk); #1;
        applied = cyc;
        @(negedge clk);
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output longint unsigned snap);
        int t = 0;
        araddr = a; arvalid = 1'b1;
        #1;
        while (!arready && t < 20) begin
            @(negedge clk); #1; t++;
        end
        check("arready", 64'(arready), 64'd1);
        snap = cyc;
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("rvalid", 64'(rvalid), 64'd1);
        check("rresp", 64'(rresp), 64'd0);
        d = rdata;
        @(negedge clk);
    endtask

    task automatic read_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        longint unsigned s;
        axi_read(a, d, s);
        check(tag, 64'(d), 64'(exp));
    endtask

    task automatic read_status(input string tag, input int ch);
        logic [31:0] d;
        longint unsigned s;
        axi_read(regaddr(ch, 4), d, s);
        check(tag, 64'(d), {62'd0, m_done(ch, s), m_busy(ch, s)});
    endtask

    task automatic read_count(input string tag, input int ch);
        logic [31:0] d;
        longint unsigned s;
        logic [63:0] exp;
        axi_read(regaddr(ch, 'h18), d, s);
        exp = m_count(ch, s);
        check({tag, "_l"}, 64'(d), 64'(exp[31:0]));
        axi_read(regaddr(ch, 'h1C), d, s);
        check({tag, "_h"}, 64'(d), 64'(exp[63:32]));
    endtask

    task automatic start_ch(input int ch, input logic [63:0] lim, input logic [31:0] pre, input logic [3:0] cfg);
        longint unsigned a;
        m_mon[ch] = 1'b0;
        m_active[ch] = 1'b0;
        axi_write(regaddr(ch, 0), 32'h2, 4'hF, a);
        axi_write(regaddr(ch, 'h10), lim[31:0], 4'hF, a);
        axi_write(regaddr(ch, 'h14), lim[63:32], 4'hF, a);
        axi_write(regaddr(ch, 8), pre, 4'hF, a);
        axi_write(regaddr(ch, 0), {28'd0, cfg}, 4'hF, a);
        m_start[ch] = a; m_lim[ch] = lim; m_pre[ch] = pre; m_per[ch] = cfg[2];
        m_active[ch] = 1'b1;
        m_mon[ch] = 1'b1;
    endtask

    task automatic wait_until(input longint unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        longint unsigned s, a;
        rst_n = 1'b0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
        for (int c = 0; c < N; c++) begin
            m_start[c] = 0; m_pre[c] = 0; m_lim[c] = 0; m_per[c] = 0; m_active[c] = 0; m_mon[c] = 0;
        end
        #12;
        check("rst_time", current_time[63:0], 64'd0);
        check("rst_run", 64'(time_running), 64'd0);
        check("rst_irq", 64'(irq), 64'd0);
        check("rst_ready", 64'({awready, wready, arready}), 64'd0);
        check("rst_valid", 64'({bvalid, rvalid}), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        read_chk("cnth_noshadow", regaddr(2, 'h1C), 32'd0);
        read_chk("cfg0_rst", regaddr(0, 0), 32'd0);

        // one-shot to completion, then hold at LIMIT
        start_ch(0, 64'd10, 32'd0, 4'h1);
        wait_until(m_start[0] + 14);
        read_status("ch0_status", 0);
        read_count("ch0_count", 0);

        // SRST while running at count 6, then restart with LIMIT unchanged
        start_ch(0, 64'd10, 32'd0, 4'h1);
        s = m_start[0];
        wait_until(s + 4);
        m_mon[0] = 1'b0;
        axi_write(regaddr(0, 0), 32'h3, 4'hF, a);
        check("srst_cnt6", current_time[63:0], 64'd6);
        check("srst_run", 64'(time_running[0]), 64'd0);
        @(negedge clk);
        check("srst_cnt0", current_time[63:0], 64'd0);
        read_chk("srst_status", regaddr(0, 4), 32'd0);
        axi_write(regaddr(0, 0), 32'h1, 4'hF, a);
        m_start[0] = a;
        m_mon[0] = 1'b1;
        wait_until(a + 12);
        read_status("restart_status", 0);

        // periodic; W1C landing on the DONE set cycle must leave DONE at 1
        start_ch(1, 64'd4, 32'd2, 4'h5);
        s = m_start[1];
        wait_until(s + 22);
        axi_write(regaddr(1, 4), 32'h2, 4'hF, a);
        read_chk("w1c_setwins", regaddr(1, 4), 32'h3);
        wait_until(s + 39);
        axi_write(regaddr(1, 4), 32'h2, 4'hF, a);
        read_chk("w1c_clear", regaddr(1, 4), 32'h1);
        wait_until(s + 49);
        read_chk("done_reset", regaddr(1, 4), 32'h3);

        // wide LIMIT readback and COUNT_L/COUNT_H pairing
        start_ch(2, 64'h1_0000_0005, 32'd0, 4'h1);
        read_chk("limh", regaddr(2, 'h14), 32'h1);
        read_chk("liml", regaddr(2, 'h10), 32'h5);
        read_count("ch2_count", 2);

        // interrupt path on ch3
        start_ch(3, 64'd3, 32'd0, 4'h9);
        s = m_start[3];
        wait_until(s + 3);
        check("irq_pre", 64'(irq), 64'd0);
        @(negedge clk);
        check("irq_set", 64'(irq), 64'(IRQ_ON));
        read_chk("cfg3", regaddr(3, 0), CFG3_EXP);
        axi_write(regaddr(3, 4), 32'h2, 4'hF, a);
        check("irq_hold", 64'(irq), 64'(IRQ_ON));
        @(negedge clk);
        check("irq_clr", 64'(irq), 64'd0);

        // AW ahead of W, then back-pressured B blocks a second write
        awaddr = regaddr(3, 8); wdata = 32'h11223344; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; check("aw_early", 64'(awready), 64'd0);
            @(negedge clk);
        end
        wvalid = 1'b1;
        #1; check("aw_hs", 64'(awready & wready), 64'd1);
        @(posedge clk); #1;
        wdata = 32'hAABBCCDD; wstrb = 4'h5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("b_hold", 64'(bvalid), 64'd1);
            check("aw_block", 64'(awready), 64'd0);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        check("b_drop", 64'(bvalid), 64'd0);
        check("aw_second", 64'(awready), 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check("b_second", 64'(bvalid), 64'd1);
        @(posedge clk);
        @(negedge clk);
        read_chk("wstrb_merge", regaddr(3, 8), 32'h11BB33DD);

        // randomized channel programs against the reference
        for (int it = 0; it < 10; it++) begin
            int ch;
            logic [63:0] lim;
            logic [31:0] pre;
            logic per;
            ch  = int'($urandom_range(0, N - 1));
            lim = 64'($urandom_range(1, 12));
            pre = 32'($urandom_range(0, 3));
            per = 1'($urandom_range(0, 1));
            start_ch(ch, lim, pre, {1'b0, per, 2'b01});
            repeat ($urandom_range(0, 60)) @(negedge clk);
            read_count($sformatf("rnd%0d_cnt", it), ch);
            read_status($sformatf("rnd%0d_st", it), ch);
        end

        read_chk("unmapped_0c", regaddr(0, 'h0C), 32'd0);
        read_chk("unmapped_ch4", regaddr(4, 0), 32'd0);
        read_chk("unmapped_ch5", regaddr(5, 'h18), 32'd0);

        // reset during an open write response
        for (int c = 0; c < N; c++) m_mon[c] = 1'b0;
        bready = 1'b0;
        awaddr = regaddr(0, 8); wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check("pre_rst_bvalid", 64'(bvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_cnt", current_time[63:0], 64'd0);
        @(negedge clk); rst_n = 1'b1; bready = 1'b1;
        @(negedge clk);
        read_chk("rst_discard", regaddr(0, 8), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
